reg_bank_sb: RTL
================

# reg_bank_sb

Parametrised successor to the core's register bank. It provides two combinational read ports, with port A able to select the PC instead of a register, and one write port with optional same-cycle write-to-read bypass. It also holds a per-register pending-write scoreboard for hazard detection and a sequential soft-clear engine. It sits between decode (read/issue) and writeback (write) in the datapath.

## Interface
- XLEN, 32, data width of registers, PC and buses
- NREG, 32, register count; power of two, ≥4; AW = $clog2(NREG)
- BYPASS, 1, 1 = a write in the current cycle is forwarded to matching reads
- clk  in  1  core clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- selA  in  AW+1  port-A select; MSB=1 selects inPC, else register selA[AW-1:0]
- selB  in  AW  port-B register select
- inPC  in  XLEN  current PC, routed to outA when selA MSB=1
- we  in  1  write enable
- rd  in  AW  write destination
- busC  in  XLEN  write data
- iss_valid  in  1  instruction issued with destination iss_rd
- iss_rd  in  AW  destination to mark pending
- clr_req  in  1  soft-clear request, single-cycle pulse sampled in IDLE
- outA  out  XLEN  port-A data
- outB  out  XLEN  port-B data
- busyA  out  1  register on port A has a pending write; 0 when PC is selected
- busyB  out  1  register on port B has a pending write
- clr_busy  out  1  soft clear in progress

## Operation
- Reset (reset=0, asynchronous):
  - all registers = 0, all pending bits = 0, FSM = IDLE, clear index = 1, clr_busy = 0.
  - outA/outB then show 0, or inPC when the PC is selected; busyA/busyB = 0.
- Register 0:
  - always reads 0.
  - writes and issues to index 0 are ignored; pending[0] is never set.
- Write: in IDLE with we=1 and rd≠0, register rd ← busC and pending[rd] ← 0.
- Issue: in IDLE with iss_valid=1 and iss_rd≠0, pending[iss_rd] ← 1.
  - If the same cycle also writes the same index, set wins: pending stays 1, because the new producer is outstanding.
- Read ports are combinational:
  - outA = inPC if selA MSB=1.
  - else busC if BYPASS=1, we=1, rd≠0, rd=selA, FSM=IDLE.
  - else register selA.
  - outB follows the same rule without the PC option.
- busyX = pending[sel] AND NOT (the bypass condition for that port). A same-cycle write therefore resolves the hazard when BYPASS=1.
- Soft-clear FSM, states IDLE and CLEAR:
  - IDLE→CLEAR when clr_req=1. On that edge all pending bits ← 0 and the index is set to 1.
  - In CLEAR, register[index] ← 0 each cycle, then index increments.
  - CLEAR→IDLE on the edge that clears index NREG-1.
  - we, iss_valid and clr_req are ignored in CLEAR; bypass is disabled.
  - Reads return current array contents, which may be partially cleared.
- Asserting reset during CLEAR aborts immediately to the reset state.
- Write data is stored unmodified at XLEN bits. Index arithmetic is AW bits; the index never wraps, because the exit is taken at NREG-1.

## Timing
- Write latency: data readable from the array one cycle after the write edge; with BYPASS=1, readable in the same cycle.
- Issue → busy: busyX=1 from the cycle after the issue edge.
- Write → busy cleared: same cycle with BYPASS=1; otherwise the next cycle.
- clr_req sampled at edge T:
  - clr_busy=1 from T through T+NREG-1 edges, i.e. exactly NREG-1 cycles.
  - The first write is accepted at the edge after clr_busy falls.
- No input is registered; all outputs are combinational from state plus inputs.

## Structure
- Package reg_bank_pkg holds:
  - the FSM state enum (ST_IDLE, ST_CLEAR);
  - the default XLEN/NREG constants;
  - the PC-select bit position helper.
- Sub-module reg_scoreboard holds:
  - the NREG pending bits, with set (issue), clear (write) and clear-all ports;
  - combinational lookup for two read indices.
- Top-level holds the register array, the bypass muxes and the soft-clear FSM.

## Test plan
- Reset then read: read all 32 regs → 0. Set selA=6'b100000 with inPC=0x0000_1000 → outA=0x0000_1000, busyA=0.
- Write and read back:
  - we=1, rd=5, busC=0xDEAD_BEEF with selA=5, BYPASS=1 → outA=0xDEAD_BEEF in the same cycle, and from the array next cycle.
  - we=1, rd=0, busC=0xFFFF_FFFF → x0 still reads 0.
- Scoreboard:
  - issue rd=7 → busyB=1 with selB=7.
  - write rd=7 later → busyB=0 in the same cycle.
  - issue+write rd=9 in the same cycle → busyB=1 with selB=9 afterwards.
- Soft clear:
  - fill regs with index*3, pulse clr_req → clr_busy=1 for 31 cycles.
  - a write to rd=4 issued during clear is ignored.
  - all regs read 0 afterwards; pending bits all 0.
- Reset mid-clear: drop reset at cycle 10 of CLEAR → clr_busy=0 at once, all regs 0. Next write rd=3=0x1234 succeeds.
- Parameter sweep: XLEN=64, NREG=16, BYPASS=0 → same-cycle read of a written register returns the old value; the new value appears next cycle; clr_busy lasts 15 cycles.

Source files
------------

// File: rtl/reg_bank_sb_pkg.sv
// reg_bank_sb shared types and constants.
// Soft-clear FSM states, default geometry, PC-select helper.
package reg_bank_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } state_t;

  localparam int DEF_XLEN = 32;
  localparam int DEF_NREG = 32;

  function automatic int pc_sel_bit(input int nreg);
    return $clog2(nreg);
  endfunction

endpackage

// File: rtl/reg_bank_sb_if.sv
// reg_bank_sb decode/writeback port bundle.
// master drives selects, write and issue; slave returns data and busy.
interface reg_bank_sb_if #(
  parameter int XLEN = 32,
  parameter int NREG = 32
);
  localparam int AW = $clog2(NREG);

  logic [AW:0]     selA;
  logic [AW-1:0]   selB;
  logic [XLEN-1:0] inPC;
  logic            we;
  logic [AW-1:0]   rd;
  logic [XLEN-1:0] busC;
  logic            iss_valid;
  logic [AW-1:0]   iss_rd;
  logic            clr_req;
  logic [XLEN-1:0] outA;
  logic [XLEN-1:0] outB;
  logic            busyA;
  logic            busyB;
  logic            clr_busy;

  modport master (
    output selA, selB, inPC,
    output we, rd, busC,
    output iss_valid, iss_rd,
    output clr_req,
    input  outA, outB,
    input  busyA, busyB,
    input  clr_busy
  );

  modport slave (
    input  selA, selB, inPC,
    input  we, rd, busC,
    input  iss_valid, iss_rd,
    input  clr_req,
    output outA, outB,
    output busyA, busyB,
    output clr_busy
  );

endinterface

// File: rtl/reg_bank_sb_scoreboard.sv
// Pending-write scoreboard: one bit per register.
// Set beats clear on the same index; clear-all beats both.
module reg_scoreboard #(
  parameter int NREG = 32,
  parameter int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          set_en,
  input  logic [AW-1:0] set_idx,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_idx,
  input  logic          clr_all,
  input  logic [AW-1:0] rd_a,
  input  logic [AW-1:0] rd_b,
  output logic          busy_a,
  output logic          busy_b
);

  logic [NREG-1:0] pending;
  logic [NREG-1:0] pending_nxt;

  always_comb begin
    pending_nxt = pending;
    if (clr_en) pending_nxt[clr_idx] = 1'b0;
    if (set_en) pending_nxt[set_idx] = 1'b1;
    if (clr_all) pending_nxt = '0;
    // x0 never has an outstanding producer
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pending <= '0;
    else        pending <= pending_nxt;
  end

  assign busy_a = pending[rd_a];
  assign busy_b = pending[rd_b];

endmodule

// File: rtl/reg_bank_sb.sv
// Register bank with PC read mux, write bypass,
// pending-write scoreboard and sequential soft clear.
module reg_bank_sb
  import reg_bank_pkg::*;
#(
  parameter int XLEN   = DEF_XLEN,
  parameter int NREG   = DEF_NREG,
  parameter int BYPASS = 1
) (
  input  logic clk,
  input  logic reset,
  reg_bank_sb_if.slave bus
);

  localparam int AW = $clog2(NREG);
  localparam int PB = pc_sel_bit(NREG);
  localparam logic [AW-1:0] LAST = AW'(NREG - 1);
  localparam logic [AW-1:0] ONE  = AW'(1);

  state_t state, state_nxt;
  logic [AW-1:0] idx;
  logic [XLEN-1:0] regs [NREG];

  logic          idle;
  logic          wr_en;
  logic          iss_en;
  logic          clr_start;
  logic          pc_sel;
  logic [AW-1:0] ia;
  logic [AW-1:0] ib;
  logic          byp_a;
  logic          byp_b;
  logic          pend_a;
  logic          pend_b;

  assign idle      = (state == ST_IDLE);
  assign wr_en     = idle && bus.we && (bus.rd != '0);
  assign iss_en    = idle && bus.iss_valid && (bus.iss_rd != '0);
  assign clr_start = idle && bus.clr_req;

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (bus.clr_req) state_nxt = ST_CLEAR;
      ST_CLEAR: if (idx == LAST)  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Index holds at LAST on exit so it never wraps to x0
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx <= ONE;
    end else if (clr_start) begin
      idx <= ONE;
    end else if (state == ST_CLEAR && idx != LAST) begin
      idx <= idx + ONE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (state == ST_CLEAR) begin
      regs[idx] <= '0;
    end else if (wr_en) begin
      regs[bus.rd] <= bus.busC;
    end
  end

  reg_scoreboard #(
    .NREG (NREG),
    .AW   (AW)
  ) u_sb (
    .clk     (clk),
    .reset   (reset),
    .set_en  (iss_en),
    .set_idx (bus.iss_rd),
    .clr_en  (wr_en),
    .clr_idx (bus.rd),
    .clr_all (clr_start),
    .rd_a    (ia),
    .rd_b    (ib),
    .busy_a  (pend_a),
    .busy_b  (pend_b)
  );

  assign pc_sel = bus.selA[PB];
  assign ia     = bus.selA[AW-1:0];
  assign ib     = bus.selB;
  assign byp_a  = (BYPASS != 0) && wr_en && (bus.rd == ia);
  assign byp_b  = (BYPASS != 0) && wr_en && (bus.rd == ib);

  always_comb begin
    bus.outA = regs[ia];
    if (pc_sel)     bus.outA = bus.inPC;
    else if (byp_a) bus.outA = bus.busC;
  end

  always_comb begin
    bus.outB = regs[ib];
    if (byp_b) bus.outB = bus.busC;
  end

  assign bus.busyA    = !pc_sel && pend_a && !byp_a;
  assign bus.busyB    = pend_b && !byp_b;
  assign bus.clr_busy = (state == ST_CLEAR);

endmodule
